alu_writeback: RTL and testbench

ALU_WRITEBACK -- requirements
Module: alu_writeback

---
 rtl/alu_writeback.sv | 179 +++++++++++++++++
 tb/tb_alu_writeback.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_writeback.sv
// Multi-cycle ALU sequencer: reads two operands, computes the result, and writes it back.
// MUL uses an 8-step shift-add loop. All other ops finish in a single EXEC cycle.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for start; latches op and register selects
// READ   | register file presents Adata/Bdata; operands are frozen
// EXEC   | one-cycle ALU result, or 8 shift-add steps for MUL
// WB     | Load high; register file writes Ddata to DS at next edge
module alu_writeback (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] op,
  input  logic [2:0] RA,
  input  logic [2:0] RB,
  input  logic [2:0] RD,
  output logic [2:0] SA,
  output logic [2:0] SB,
  input  logic [7:0] Adata,
  input  logic [7:0] Bdata,
  output logic [7:0] Ddata,
  output logic [2:0] DS,
  output logic       Load,
  output logic       busy,
  output logic       C,
  output logic       Z
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t      state_q;
  logic [2:0]  op_q;
  logic [7:0]  opa_q;
  logic [7:0]  opb_q;
  logic [15:0] acc_q;
  logic [2:0]  cnt_q;
  logic [2:0]  sa_q;
  logic [2:0]  sb_q;
  logic [2:0]  ds_q;
  logic [7:0]  ddata_q;
  logic        load_q;
  logic        busy_q;
  logic        c_q;
  logic        z_q;

  logic [7:0]  alu_res_d;
  logic        alu_c_d;
  logic [15:0] mul_sum_d;

  always_comb begin
    alu_res_d = 8'h00;
    alu_c_d   = 1'b0;
    case (op_q)
      OP_ADD: {alu_c_d, alu_res_d} = {1'b0, opa_q} + {1'b0, opb_q};
      OP_SUB: begin
        alu_res_d = opa_q - opb_q;
        alu_c_d   = (opa_q < opb_q);
      end
      OP_AND: alu_res_d = opa_q & opb_q;
      OP_OR:  alu_res_d = opa_q | opb_q;
      OP_XOR: alu_res_d = opa_q ^ opb_q;
      OP_SHL: begin
        alu_res_d = {opa_q[6:0], 1'b0};
        alu_c_d   = opa_q[7];
      end
      OP_SHR: begin
        alu_res_d = {1'b0, opa_q[7:1]};
        alu_c_d   = opa_q[0];
      end
      default: begin
        alu_res_d = 8'h00;
        alu_c_d   = 1'b0;
      end
    endcase
  end

  // One multiplier bit per step, LSB first; the partial product is the multiplicand shifted by the step index.
  always_comb begin
    mul_sum_d = acc_q;
    if (opb_q[cnt_q]) begin
      mul_sum_d = acc_q + ({8'h00, opa_q} << cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= 3'd0;
      opa_q   <= 8'h00;
      opb_q   <= 8'h00;
      acc_q   <= 16'h0000;
      cnt_q   <= 3'd0;
      sa_q    <= 3'd0;
      sb_q    <= 3'd0;
      ds_q    <= 3'd0;
      ddata_q <= 8'h00;
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q    <= op;
            sa_q    <= RA;
            sb_q    <= RB;
            ds_q    <= RD;
            busy_q  <= 1'b1;
            state_q <= S_READ;
          end
        end
        S_READ: begin
          opa_q   <= Adata;
          opb_q   <= Bdata;
          acc_q   <= 16'h0000;
          cnt_q   <= 3'd0;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          if (op_q == OP_MUL) begin
            if (cnt_q == 3'd7) begin
              acc_q   <= mul_sum_d;
              ddata_q <= mul_sum_d[7:0];
              c_q     <= |mul_sum_d[15:8];
              z_q     <= (mul_sum_d[7:0] == 8'h00);
              load_q  <= 1'b1;
              state_q <= S_WB;
            end else begin
              acc_q <= mul_sum_d;
              cnt_q <= cnt_q + 3'd1;
            end
          end else begin
            ddata_q <= alu_res_d;
            c_q     <= alu_c_d;
            z_q     <= (alu_res_d == 8'h00);
            load_q  <= 1'b1;
            state_q <= S_WB;
          end
        end
        S_WB: begin
          load_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          load_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign SA    = sa_q;
  assign SB    = sb_q;
  assign DS    = ds_q;
  assign Ddata = ddata_q;
  assign Load  = load_q;
  assign busy  = busy_q;
  assign C     = c_q;
  assign Z     = z_q;

endmodule

// File: tb/tb_alu_writeback.sv
// Scoreboard bench for alu_writeback: a register-file model around the DUT,
// with randomized ops checked against an arithmetic reference model.
module tb_alu_writeback;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] op = 3'd0;
  logic [2:0] RA = 3'd0;
  logic [2:0] RB = 3'd0;
  logic [2:0] RD = 3'd0;
  logic [2:0] SA;
  logic [2:0] SB;
  logic [7:0] Adata;
  logic [7:0] Bdata;
  logic [7:0] Ddata;
  logic [2:0] DS;
  logic       Load;
  logic       busy;
  logic       C;
  logic       Z;

  alu_writeback dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .RA(RA), .RB(RB), .RD(RD), .SA(SA), .SB(SB),
    .Adata(Adata), .Bdata(Bdata), .Ddata(Ddata), .DS(DS),
    .Load(Load), .busy(busy), .C(C), .Z(Z)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [2:0] ra;
    logic [2:0] rb;
    logic [2:0] rd;
    int         k;
  } req_t;

  req_t q[$];

  logic [7:0] rf  [8];
  logic [7:0] mrf [8];
  logic       pl_en = 1'b0;
  logic [2:0] pl_addr = 3'd0;
  logic [7:0] pl_data = 8'h00;
  logic       m_wr_en = 1'b0;
  logic [2:0] m_wr_addr = 3'd0;
  logic [7:0] m_wr_data = 8'h00;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int n_loads = 0;

  assign Adata = rf[SA];
  assign Bdata = rf[SB];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (Load) rf[DS] <= Ddata;
    if (pl_en) begin
      rf[pl_addr]  <= pl_data;
      mrf[pl_addr] <= pl_data;
    end
    if (m_wr_en) mrf[m_wr_addr] <= m_wr_data;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain integer arithmetic on the op table.
  task automatic ref_alu(input logic [2:0] o, input int a, input int b,
                         output logic [7:0] r, output logic c);
    int full;
    full = 0;
    c = 1'b0;
    case (o)
      3'd0: begin full = a + b; c = (full > 255); end
      3'd1: begin full = a - b; c = (a < b); end
      3'd2: full = a & b;
      3'd3: full = a | b;
      3'd4: full = a ^ b;
      3'd5: begin full = a * 2; c = (a >= 128); end
      3'd6: begin full = a / 2; c = (a % 2 == 1); end
      default: begin full = a * b; c = (full > 255); end
    endcase
    r = full[7:0];
  endtask

  // Monitor: pops the oldest accepted request whenever Load is presented.
  initial begin
    req_t       e;
    logic [7:0] er;
    logic       ec;
    logic       prev_load;
    prev_load = 1'b0;
    forever begin
      @(negedge clk);
      m_wr_en = 1'b0;
      if (Load) begin
        chk("busy_during_wb", {31'd0, busy}, 32'd1);
        if (prev_load) begin
          n_checks++;
          n_fail++;
          $display("FAIL load_width: Load high on consecutive cycles, required single cycle");
        end
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL spurious_load: Load=1 with DS=%0d Ddata=0x%0h, required no write", DS, Ddata);
        end else begin
          e = q.pop_front();
          ref_alu(e.op, int'(mrf[e.ra]), int'(mrf[e.rb]), er, ec);
          chk("DS", {29'd0, DS}, {29'd0, e.rd});
          chk("Ddata", {24'd0, Ddata}, {24'd0, er});
          chk("C", {31'd0, C}, {31'd0, ec});
          chk("Z", {31'd0, Z}, {31'd0, (er == 8'h00)});
          chk("latency", cyc, e.k + ((e.op == 3'd7) ? 9 : 2));
          m_wr_en   = 1'b1;
          m_wr_addr = e.rd;
          m_wr_data = er;
          n_loads++;
        end
      end
      prev_load = Load;
    end
  end

  task automatic wait_idle();
    int t;
    @(negedge clk);
    t = 0;
    while (busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (busy) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: busy=1 after %0d cycles, required 0", t);
    end
  endtask

  task automatic poke(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Returns at the negedge just after the accepting edge.
  task automatic issue(input logic [2:0] o, input logic [2:0] a, input logic [2:0] b, input logic [2:0] d);
    wait_idle();
    start = 1'b1; op = o; RA = a; RB = b; RD = d;
    q.push_back('{o, a, b, d, cyc + 1});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_SA"},    {29'd0, SA}, 32'd0);
    chk({tag, "_SB"},    {29'd0, SB}, 32'd0);
    chk({tag, "_DS"},    {29'd0, DS}, 32'd0);
    chk({tag, "_Ddata"}, {24'd0, Ddata}, 32'd0);
    chk({tag, "_Load"},  {31'd0, Load}, 32'd0);
    chk({tag, "_busy"},  {31'd0, busy}, 32'd0);
    chk({tag, "_C"},     {31'd0, C}, 32'd0);
    chk({tag, "_Z"},     {31'd0, Z}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int pushes;
    int loads0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("por");
    rst = 1'b0;
    for (int i = 0; i < 8; i++) poke(i[2:0], 8'($urandom_range(0, 255)));

    // Directed vectors
    poke(3'd1, 8'hF0); poke(3'd2, 8'h20);
    issue(3'd0, 3'd1, 3'd2, 3'd3);
    poke(3'd4, 8'h05); poke(3'd5, 8'h05);
    issue(3'd1, 3'd4, 3'd5, 3'd6);
    poke(3'd1, 8'h03); poke(3'd2, 8'h05);
    issue(3'd1, 3'd1, 3'd2, 3'd7);
    wait_idle();
    poke(3'd1, 8'h0C); poke(3'd2, 8'h15);
    issue(3'd7, 3'd1, 3'd2, 3'd3);
    wait_idle();
    poke(3'd1, 8'h10); poke(3'd2, 8'h10);
    issue(3'd7, 3'd1, 3'd2, 3'd4);
    wait_idle();
    poke(3'd1, 8'hC0);
    issue(3'd5, 3'd1, 3'd1, 3'd1);
    wait_idle();
    chk("R1_after_shl", {24'd0, rf[1]}, 32'h80);
    issue(3'd3, 3'd1, 3'd1, 3'd5);
    wait_idle();

    // start held high for 12 cycles across a MUL
    loads0 = n_loads;
    pushes = 0;
    poke(3'd6, 8'h07); poke(3'd7, 8'h09);
    wait_idle();
    for (int i = 0; i < 12; i++) begin
      start = 1'b1; op = 3'd7; RA = 3'd6; RB = 3'd7; RD = 3'd2;
      if (!busy) begin
        q.push_back('{3'd7, 3'd6, 3'd7, 3'd2, cyc + 1});
        pushes++;
      end
      @(negedge clk);
    end
    start = 1'b0;
    wait_idle();
    chk("hold_accepts", pushes, 2);
    chk("hold_loads", n_loads - loads0, pushes);

    // rst at edge k+5 of a MUL aborts it; then ADD completes normally
    issue(3'd7, 3'd6, 3'd7, 3'd0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    chk_reset_outputs("abort");
    repeat (12) @(negedge clk);
    chk("abort_no_load", n_loads - loads0, pushes);
    poke(3'd1, 8'h33); poke(3'd2, 8'h44);
    issue(3'd0, 3'd1, 3'd2, 3'd3);
    wait_idle();

    // Randomized ops with ignored start pulses while busy
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        wait_idle();
        poke(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
      end
      issue(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      if ($urandom_range(0, 1) == 1) begin
        repeat (3) begin
          start = busy ? 1'($urandom_range(0, 1)) : 1'b0;
          op = 3'($urandom_range(0, 7)); RD = 3'($urandom_range(0, 7));
          @(negedge clk);
        end
        start = 1'b0;
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle();
    repeat (2) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    for (int i = 0; i < 8; i++) chk("regfile", {24'd0, rf[i]}, {24'd0, mrf[i]});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
